fp_mult_norm_round_pipe: RTL and testbench
==========================================

FP_MULT_NORM_ROUND_PIPE -- requirements
Module: fp_mult_norm_round_pipe

Interface
REQ-001 Parameters SHALL be: SIG_W, default 23, stored fraction width; EX_W, default 8, exponent field width.
REQ-002 The ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the input beat this cycle.
- mant_mult  in  2*SIG_W+2  raw significand product; leading one at bit 2*SIG_W+1 or bit 2*SIG_W.
- exp_sub  in  EX_W+2  two's-complement biased exponent (ea+eb-bias).
- sign_in  in  1  result sign.
- rnd_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result beat.
- result  out  1+EX_W+SIG_W  packed {sign, exponent, fraction}.
- flag_ovf, flag_unf, flag_inx  out  1 each  overflow, underflow, inexact for the result beat.

Function
REQ-003 A beat SHALL be accepted when in_valid && in_ready, and SHALL be delivered when out_valid && out_ready.
REQ-004 The datapath SHALL be two register stages: S1 normalise, S2 round/pack; latency is 2 cycles from acceptance to out_valid with no stall.
REQ-005 Each stage SHALL advance when it is empty or its successor advances; in_ready = !s1_valid || s1_advance, combinational from out_ready, with no bubble at full throughput.
REQ-006 When out_valid=1 && out_ready=0, result, flags and out_valid SHALL hold stable, and no accepted beat SHALL be dropped, duplicated or reordered.
REQ-007 sign_in and rnd_mode SHALL be captured with their beat and travel with it.
REQ-008 S1: if mant_mult[2*SIG_W+1]=1 then frac=mant_mult[2*SIG_W:SIG_W+1], guard=mant_mult[SIG_W], sticky=OR(mant_mult[SIG_W-1:0]), exp=exp_sub+1; otherwise frac=mant_mult[2*SIG_W-1:SIG_W], guard=mant_mult[SIG_W-1], sticky=OR(mant_mult[SIG_W-2:0]), exp=exp_sub.
REQ-009 Exponent arithmetic SHALL be signed, EX_W+2 bits wide; the increment is lossless for all legal inputs.
REQ-010 S2 increment SHALL be: RNE guard&&(sticky||frac[0]); RTZ 0; RUP !sign&&(guard||sticky); RDN sign&&(guard||sticky).
REQ-011 If the increment carries out of an all-ones frac, frac SHALL become 0 and exp SHALL increase by 1.
REQ-012 flag_inx SHALL be guard||sticky, and SHALL also be 1 whenever flag_ovf or flag_unf is 1.
REQ-013 Overflow: if the post-rounding exp >= 2^EX_W-1, flag_ovf=1; the result SHALL be +/-infinity (exp all ones, frac 0) for RNE, RUP with sign 0, and RDN with sign 1; otherwise it SHALL be the maximum finite value (exp 2^EX_W-2, frac all ones).
REQ-014 Underflow: if the post-rounding exp <= 0, flag_unf=1 and the result SHALL be signed zero (flush; no subnormal output).
REQ-015 Otherwise result SHALL be {sign, exp[EX_W-1:0], frac}, with flag_ovf=flag_unf=0.
REQ-016 Simultaneous accept and deliver in the same cycle SHALL be legal at every occupancy.

Reset
REQ-017 While rst_n=0, out_valid=0, the internal stage valids are 0, in_ready=1, and result and all flags are 0.
REQ-018 Assertion mid-operation SHALL discard all in-flight beats immediately; the first beat accepted after release SHALL appear 2 cycles later.

Verification (SIG_W=23, EX_W=8)
REQ-019 mant_mult=0x900000000000, exp_sub=127, sign 0, RNE -> after 2 cycles result=0x40100000, all flags 0.
REQ-020 mant_mult=0x7FFFFFC00000, exp_sub=127, RNE -> 0x40000000, flag_inx=1 (rounding carry); the same beat with RTZ -> 0x3FFFFFFF, flag_inx=1.
REQ-021 mant_mult=0x800000000000, exp_sub=254 -> RNE gives 0x7F800000; sign 1 with RUP gives 0xFF7FFFFF; both with flag_ovf=1 and flag_inx=1.
REQ-022 mant_mult=0x400000000000, exp_sub=0 (and separately exp_sub=-5), sign 1 -> 0x80000000, flag_unf=1, flag_inx=1.
REQ-023 Back-to-back beats A, B, C with out_ready=0 for 4 cycles -> in_ready falls after 2 beats are held, C waits, result A stays stable, and A, B, C are delivered in order once out_ready=1.
REQ-024 rst_n pulsed low with 2 beats in flight -> out_valid=0 at once, those beats are never delivered, and a new beat appears 2 cycles after it is accepted.

Source files
------------

// File: rtl/fp_mult_norm_round_pipe.sv
// Normalise/round/pack back end of a floating-point multiplier.
// Two elastic register stages (S1 normalise, S2 round+pack) with valid/ready flow control.
module fp_mult_norm_round_pipe #(
   parameter int SIG_W = 23,
   parameter int EX_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*SIG_W+1:0]     mant_mult,
   input  logic [EX_W+1:0]        exp_sub,
   input  logic                   sign_in,
   input  logic [1:0]             rnd_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EX_W+SIG_W:0]    result,
   output logic                   flag_ovf,
   output logic                   flag_unf,
   output logic                   flag_inx
);

   localparam int MW = 2*SIG_W + 2;
   localparam int XW = EX_W + 2;
   localparam logic signed [XW-1:0] EXP_INF = XW'((1 << EX_W) - 1);

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RUP = 2'b10,
      RM_RDN = 2'b11
   } rnd_t;

   // ---------------- S1: normalise ----------------
   logic [SIG_W-1:0]       w_n_frac;
   logic                   w_n_guard;
   logic                   w_n_sticky;
   logic [XW-1:0]          w_n_exp;

   logic                   r_s1_valid;
   logic [SIG_W-1:0]       r_s1_frac;
   logic                   r_s1_guard;
   logic                   r_s1_sticky;
   logic signed [XW-1:0]   r_s1_exp;
   logic                   r_s1_sign;
   rnd_t                   r_s1_rnd;

   logic                   w_s2_ready;

   always_comb begin
      w_n_frac   = '0;
      w_n_guard  = 1'b0;
      w_n_sticky = 1'b0;
      w_n_exp    = exp_sub;
      if (mant_mult[MW-1]) begin
         w_n_frac   = mant_mult[2*SIG_W:SIG_W+1];
         w_n_guard  = mant_mult[SIG_W];
         w_n_sticky = |mant_mult[SIG_W-1:0];
         w_n_exp    = exp_sub + XW'(1);
      end else begin
         w_n_frac   = mant_mult[2*SIG_W-1:SIG_W];
         w_n_guard  = mant_mult[SIG_W-1];
         w_n_sticky = |mant_mult[SIG_W-2:0];
         w_n_exp    = exp_sub;
      end
   end

   // Each stage refills when empty or when its contents move on this same edge.
   assign w_s2_ready = !out_valid || out_ready;
   assign in_ready   = !r_s1_valid || w_s2_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_frac   <= '0;
         r_s1_guard  <= 1'b0;
         r_s1_sticky <= 1'b0;
         r_s1_exp    <= '0;
         r_s1_sign   <= 1'b0;
         r_s1_rnd    <= RM_RNE;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_frac   <= w_n_frac;
            r_s1_guard  <= w_n_guard;
            r_s1_sticky <= w_n_sticky;
            r_s1_exp    <= w_n_exp;
            r_s1_sign   <= sign_in;
            r_s1_rnd    <= rnd_t'(rnd_mode);
         end
      end
   end

   // ---------------- S2: round and pack ----------------
   logic                   w_inc;
   logic [SIG_W:0]         w_frac_sum;
   logic [SIG_W-1:0]       w_frac_rnd;
   logic signed [XW-1:0]   w_exp_rnd;
   logic                   w_ovf;
   logic                   w_unf;
   logic                   w_inx;
   logic                   w_to_inf;
   logic [EX_W+SIG_W:0]    w_pack;

   always_comb begin
      w_inc = 1'b0;
      case (r_s1_rnd)
         RM_RNE: w_inc = r_s1_guard && (r_s1_sticky || r_s1_frac[0]);
         RM_RTZ: w_inc = 1'b0;
         RM_RUP: w_inc = !r_s1_sign && (r_s1_guard || r_s1_sticky);
         RM_RDN: w_inc = r_s1_sign && (r_s1_guard || r_s1_sticky);
         default: w_inc = 1'b0;
      endcase
   end

   // A carry out of an all-ones fraction leaves the low bits zero and bumps the exponent.
   assign w_frac_sum = {1'b0, r_s1_frac} + {{SIG_W{1'b0}}, w_inc};
   assign w_frac_rnd = w_frac_sum[SIG_W-1:0];
   assign w_exp_rnd  = r_s1_exp + {{(XW-1){1'b0}}, w_frac_sum[SIG_W]};

   assign w_ovf    = (w_exp_rnd >= EXP_INF);
   assign w_unf    = w_exp_rnd[XW-1] || (w_exp_rnd == '0);
   assign w_inx    = r_s1_guard || r_s1_sticky || w_ovf || w_unf;
   assign w_to_inf = (r_s1_rnd == RM_RNE)
                  || ((r_s1_rnd == RM_RUP) && !r_s1_sign)
                  || ((r_s1_rnd == RM_RDN) && r_s1_sign);

   always_comb begin
      w_pack = '0;
      if (w_ovf) begin
         if (w_to_inf)
            w_pack = {r_s1_sign, {EX_W{1'b1}}, {SIG_W{1'b0}}};
         else
            w_pack = {r_s1_sign, {(EX_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}};
      end else if (w_unf) begin
         w_pack = {r_s1_sign, {(EX_W+SIG_W){1'b0}}};
      end else begin
         w_pack = {r_s1_sign, w_exp_rnd[EX_W-1:0], w_frac_rnd};
      end
   end

   logic                   r_out_valid;
   logic [EX_W+SIG_W:0]    r_result;
   logic                   r_ovf;
   logic                   r_unf;
   logic                   r_inx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_inx       <= 1'b0;
      end else if (w_s2_ready) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= w_pack;
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
            r_inx    <= w_inx;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign flag_ovf  = r_ovf;
   assign flag_unf  = r_unf;
   assign flag_inx  = r_inx;

endmodule

// File: tb/tb_fp_mult_norm_round_pipe.sv
// Scoreboard bench for fp_mult_norm_round_pipe (SIG_W=23, EX_W=8) with hand-computed vectors.
module tb_fp_mult_norm_round_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [47:0] mant_mult = '0;
   logic [9:0]  exp_sub = '0;
   logic        sign_in = 1'b0;
   logic [1:0]  rnd_mode = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        flag_ovf;
   logic        flag_unf;
   logic        flag_inx;

   always #5 clk = ~clk;

   fp_mult_norm_round_pipe #(.SIG_W(23), .EX_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mant_mult(mant_mult), .exp_sub(exp_sub), .sign_in(sign_in), .rnd_mode(rnd_mode),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
   );

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // Monitor: pops on every delivered beat; while stalled the head must be held on the outputs.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got %0h expected none", result);
         end else if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("flags", 64'({flag_ovf, flag_unf, flag_inx}), 64'({e.ovf, e.unf, e.inx}));
         end else begin
            check("stall_hold", 64'({result, flag_ovf, flag_unf, flag_inx}),
                  64'({sb[0].res, sb[0].ovf, sb[0].unf, sb[0].inx}));
         end
      end
   end

   task automatic send(input logic [47:0] m, input logic [9:0] e, input logic s,
                       input logic [1:0] rm, input exp_t x);
      int n;
      mant_mult = m;
      exp_sub   = e;
      sign_in   = s;
      rnd_mode  = rm;
      in_valid  = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
         end
      end
      sb.push_back(x);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() == 0) passed++;
      else $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
   endtask

   localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_result", 64'({result, flag_ovf, flag_unf, flag_inx}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed vectors, full throughput
      send(48'h900000000000, 10'd127, 1'b0, RNE, '{32'h40100000, 1'b0, 1'b0, 1'b0});
      send(48'h7FFFFFC00000, 10'd127, 1'b0, RNE, '{32'h40000000, 1'b0, 1'b0, 1'b1});
      send(48'h7FFFFFC00000, 10'd127, 1'b0, RTZ, '{32'h3FFFFFFF, 1'b0, 1'b0, 1'b1});
      send(48'h800000000000, 10'd254, 1'b0, RNE, '{32'h7F800000, 1'b1, 1'b0, 1'b1});
      send(48'h800000000000, 10'd254, 1'b1, RUP, '{32'hFF7FFFFF, 1'b1, 1'b0, 1'b1});
      send(48'h800000000000, 10'd254, 1'b0, RTZ, '{32'h7F7FFFFF, 1'b1, 1'b0, 1'b1});
      send(48'h800000000000, 10'd254, 1'b1, RDN, '{32'hFF800000, 1'b1, 1'b0, 1'b1});
      send(48'h800000000000, 10'd253, 1'b0, RNE, '{32'h7F000000, 1'b0, 1'b0, 1'b0});
      send(48'h400000000000, 10'd0,   1'b1, RNE, '{32'h80000000, 1'b0, 1'b1, 1'b1});
      send(48'h400000000000, 10'h3FB, 1'b1, RNE, '{32'h80000000, 1'b0, 1'b1, 1'b1});
      send(48'h400000000000, 10'd1,   1'b0, RNE, '{32'h00800000, 1'b0, 1'b0, 1'b0});
      send(48'h400000000001, 10'd127, 1'b0, RUP, '{32'h3F800001, 1'b0, 1'b0, 1'b1});
      send(48'h400000000001, 10'd127, 1'b0, RDN, '{32'h3F800000, 1'b0, 1'b0, 1'b1});
      send(48'h400000000001, 10'd127, 1'b1, RDN, '{32'hBF800001, 1'b0, 1'b0, 1'b1});
      send(48'h400000400000, 10'd127, 1'b0, RNE, '{32'h3F800000, 1'b0, 1'b0, 1'b1});
      send(48'h400000C00000, 10'd127, 1'b0, RNE, '{32'h3F800002, 1'b0, 1'b0, 1'b1});
      drain();

      // Backpressure: A and B fill both stages, C must wait, A held stable
      @(posedge clk);
      #1 out_ready = 1'b0;
      fork
         begin
            send(48'h900000000000, 10'd127, 1'b0, RNE, '{32'h40100000, 1'b0, 1'b0, 1'b0});
            send(48'h7FFFFFC00000, 10'd127, 1'b0, RTZ, '{32'h3FFFFFFF, 1'b0, 1'b0, 1'b1});
            send(48'h800000000000, 10'd254, 1'b0, RNE, '{32'h7F800000, 1'b1, 1'b0, 1'b1});
         end
         begin
            repeat (3) @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            repeat (2) @(negedge clk);
            check("stall_in_ready_late", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two beats in flight
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(48'h900000000000, 10'd127, 1'b0, RNE, '{32'h40100000, 1'b0, 1'b0, 1'b0});
      send(48'h800000000000, 10'd254, 1'b0, RNE, '{32'h7F800000, 1'b1, 1'b0, 1'b1});
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      mant_mult = 48'h400000C00000;
      exp_sub   = 10'd127;
      sign_in   = 1'b1;
      rnd_mode  = RNE;
      in_valid  = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      sb.push_back('{32'hBF800002, 1'b0, 1'b0, 1'b1});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("latency_cycle1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("latency_cycle2", 64'(out_valid), 64'd1);
      drain();
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

endmodule
